// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        I_FILL  = 2'b01,
        D_FILL  = 2'b10,
        D_WRITE = 2'b11
    } arb_state_t;

    localparam int WORDS_PER_BLOCK   = 8;
    localparam int MEM_LAT           = 4;
    localparam int BLOCK_OFFSET_BITS = 4;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_fill_counter.sv
// Issue/receive word counters for one block fill.
module mem_fill_counter
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mem_data_valid,
    input  logic       clear,
    output logic       issue_active,
    output logic [2:0] issue_idx,
    output logic [2:0] word_idx,
    output logic       last_word
);
    logic [3:0] issue_cnt;
    logic [2:0] rcv_cnt;

    assign issue_active = start && (issue_cnt < 4'(WORDS_PER_BLOCK));
    assign issue_idx    = issue_cnt[2:0];
    assign word_idx     = rcv_cnt;
    assign last_word    = start && mem_data_valid && (rcv_cnt == 3'(WORDS_PER_BLOCK - 1));

    // Counting is gated by start, so stray data_valid outside a fill is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            issue_cnt <= '0;
            rcv_cnt   <= '0;
        end else if (start) begin
            if (issue_active)   issue_cnt <= issue_cnt + 4'd1;
            if (mem_data_valid) rcv_cnt   <= rcv_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between I-cache fills and D-cache fills/stores
// in front of the single multicycle main memory.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_grant,
    output logic              i_data_valid,
    output logic [2:0]        i_word_idx,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_grant,
    output logic              d_data_valid,
    output logic [2:0]        d_word_idx,
    output logic              d_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_data_valid,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << BLOCK_OFFSET_BITS) - 1);

    arb_state_t        state;
    logic              last_grant;
    logic [ADDR_W-1:0] base_addr;
    logic [DATA_W-1:0] wdata_q;
    logic              fill, issue_active, last_word;
    logic [2:0]        issue_idx, word_idx;

    assign fill = (state == I_FILL) || (state == D_FILL);

    mem_fill_counter u_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (fill),
        .mem_data_valid(mem_data_valid),
        .clear         (last_word),
        .issue_active  (issue_active),
        .issue_idx     (issue_idx),
        .word_idx      (word_idx),
        .last_word     (last_word)
    );

    // I wins when alone or when D held the previous grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
            base_addr  <= '0;
            wdata_q    <= '0;
            i_grant    <= 1'b0;
            d_grant    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req && (!d_req || last_grant == GRANT_D)) begin
                        state      <= I_FILL;
                        last_grant <= GRANT_I;
                        base_addr  <= i_addr & BLK_MASK;
                        i_grant    <= 1'b1;
                        busy       <= 1'b1;
                    end else if (d_req) begin
                        state      <= d_we ? D_WRITE : D_FILL;
                        last_grant <= GRANT_D;
                        base_addr  <= d_we ? d_addr : (d_addr & BLK_MASK);
                        wdata_q    <= d_wdata;
                        d_grant    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                I_FILL, D_FILL: begin
                    if (last_word) begin
                        state   <= IDLE;
                        i_grant <= 1'b0;
                        d_grant <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                D_WRITE: begin
                    state   <= IDLE;
                    d_grant <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_enable = issue_active || (state == D_WRITE);
    assign mem_wr     = (state == D_WRITE);
    assign mem_addr   = !mem_enable ? '0 :
                        mem_wr      ? base_addr :
                                      base_addr + ADDR_W'({issue_idx, 1'b0});
    assign mem_wdata  = mem_wr ? wdata_q : '0;
    assign rd_data    = mem_data_out;

    assign i_data_valid = (state == I_FILL) && mem_data_valid;
    assign d_data_valid = (state == D_FILL) && mem_data_valid;
    assign i_word_idx   = i_data_valid ? word_idx : 3'd0;
    assign d_word_idx   = d_data_valid ? word_idx : 3'd0;
    assign i_done       = (state == I_FILL) && last_word;
    assign d_done       = ((state == D_FILL) && last_word) || (state == D_WRITE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed and random rounds against a
// transaction-level model with a fixed-latency memory behind the DUT.
module tb_mem_arbiter;
    logic        clk, rst_n;
    logic        i_req, i_grant, i_data_valid, i_done;
    logic [15:0] i_addr;
    logic [2:0]  i_word_idx, d_word_idx;
    logic        d_req, d_we, d_grant, d_data_valid, d_done;
    logic [15:0] d_addr, d_wdata, rd_data;
    logic        mem_enable, mem_wr, mem_data_valid, busy;
    logic [15:0] mem_addr, mem_wdata, mem_data_out;

    logic        stray;
    logic [3:0]  vpipe;
    logic [3:0][15:0] apipe;
    int          checks = 0, errs = 0;
    bit          lg_d = 1'b1;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant),
        .i_data_valid(i_data_valid), .i_word_idx(i_word_idx), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_data_valid(d_data_valid), .d_word_idx(d_word_idx),
        .d_done(d_done), .rd_data(rd_data),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_data_out(mem_data_out),
        .mem_data_valid(mem_data_valid), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // Read returns 4 cycles after the issue cycle; memory shares the reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            vpipe <= '0;
            apipe <= '0;
        end else begin
            vpipe <= {vpipe[2:0], mem_enable & ~mem_wr};
            apipe <= {apipe[2:0], mem_addr};
        end
    end
    assign mem_data_valid = vpipe[3] | stray;
    assign mem_data_out   = vpipe[3] ? mem_word(apipe[3]) : 16'h0;

    initial begin
        #500000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk();
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_i_grant", i_grant, 0);
        chk("idle_d_grant", d_grant, 0);
        chk("idle_mem_en", mem_enable, 0);
    endtask

    // Called at cycle 0 (IDLE, request already driven); ends at the done cycle.
    task automatic do_txn(input bit side_d, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input int late, input bit stray_wr);
        int          n;
        logic [15:0] base;
        bit          en, v;
        n    = we ? 1 : 12;
        base = we ? addr : (addr & 16'hFFF0);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            en = we || (c <= 8);
            v  = !we && (c >= 5);
            chk("i_grant", i_grant, !side_d);
            chk("d_grant", d_grant, side_d);
            chk("busy", busy, 1);
            chk("mem_en", mem_enable, en);
            chk("mem_wr", mem_wr, we);
            if (en) chk("mem_addr", mem_addr, we ? 32'(addr) : 32'(base) + 2 * (c - 1));
            if (we) chk("mem_wdata", mem_wdata, wdata);
            chk("i_dv", i_data_valid, v && !side_d);
            chk("d_dv", d_data_valid, v && side_d);
            if (v) begin
                chk("word_idx", side_d ? d_word_idx : i_word_idx, c - 5);
                chk("rd_data", rd_data, mem_word(base + 16'(2 * (c - 5))));
            end
            chk("i_done", i_done, !side_d && c == n);
            chk("d_done", d_done, side_d && c == n);
            if (stray_wr && we) begin
                stray = 1'b1;
                #1;
                chk("stray_wr_dv", d_data_valid, 0);
                chk("stray_wr_done", d_done, 1);
                stray = 1'b0;
            end
            if (c == late) begin
                if (side_d) i_req = 1'b1; else d_req = 1'b1;
            end
            if (c == n) begin
                if (side_d) d_req = 1'b0; else i_req = 1'b0;
            end
        end
    endtask

    // pat: 0 I only, 1 D only, 2 tie, 3 I then D arrives mid-I, 4 D then I mid-D
    task automatic run_round(input int pat, input logic [15:0] ia, input bit dwe,
                             input logic [15:0] da, input logic [15:0] dwd, input bit stray_on);
        bit win_d;
        int late;
        i_addr = ia; d_we = dwe; d_addr = da; d_wdata = dwd;
        if (stray_on) begin
            stray = 1'b1;
            #1;
            chk("stray_idle_i_dv", i_data_valid, 0);
            chk("stray_idle_d_dv", d_data_valid, 0);
            chk("stray_idle_done", {i_done, d_done}, 0);
            stray = 1'b0;
        end
        case (pat)
            0, 3:    begin i_req = 1'b1; win_d = 1'b0; end
            1, 4:    begin d_req = 1'b1; win_d = 1'b1; end
            default: begin i_req = 1'b1; d_req = 1'b1; win_d = !lg_d; end
        endcase
        late = (pat >= 3) ? int'($urandom_range(1, (win_d && dwe) ? 1 : 12)) : 0;
        do_txn(win_d, win_d && dwe, win_d ? da : ia, dwd, late, stray_on);
        lg_d = win_d;
        idle_chk();
        if (pat >= 2) begin
            do_txn(!win_d, !win_d && dwe, !win_d ? da : ia, dwd, 0, stray_on);
            lg_d = !win_d;
            idle_chk();
        end
    endtask

    initial begin
        rst_n = 1'b0; stray = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_grants", {i_grant, d_grant}, 0);
        chk("rst_mem", {mem_enable, mem_wr, mem_addr, mem_wdata}, 0);
        chk("rst_rx", {i_data_valid, d_data_valid, i_done, d_done}, 0);
        rst_n = 1'b1;
        idle_chk();

        run_round(0, 16'h1236, 1'b0, 16'h0, 16'h0, 1'b0);
        run_round(1, 16'h0, 1'b1, 16'h0044, 16'hBEEF, 1'b1);
        run_round(2, 16'h3008, 1'b0, 16'h2000, 16'h0, 1'b0);
        run_round(2, 16'h5670, 1'b0, 16'h2104, 16'h0, 1'b0);
        run_round(3, 16'h7000, 1'b0, 16'h0800, 16'h0, 1'b0);
        run_round(0, 16'h9abc, 1'b0, 16'h0, 16'h0, 1'b1);

        // Abort an I-fill after one word has come back.
        i_addr = 16'h4444; i_req = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_grants", {i_grant, d_grant}, 0);
        chk("abort_mem", {mem_enable, mem_wr, mem_addr, mem_wdata}, 0);
        chk("abort_rx", {i_data_valid, d_data_valid, i_done, d_done, i_word_idx, d_word_idx}, 0);
        chk("abort_rd_data", rd_data, 0);
        i_req = 1'b0; rst_n = 1'b1; lg_d = 1'b1;
        idle_chk();
        run_round(0, 16'h4444, 1'b0, 16'h0, 16'h0, 1'b0);

        for (int r = 0; r < 16; r++) begin
            logic [15:0] ia, da, dwd;
            bit          dwe;
            ia  = 16'($urandom);
            dwe = 1'($urandom_range(0, 1));
            da  = 16'($urandom) & 16'hFFFE;
            dwd = 16'($urandom);
            run_round(int'($urandom_range(0, 4)), ia, dwe, da, dwd, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
